// File: rtl/riscv_pkg.sv
// Shared datapath constants, ALU/result encodings and the packed decode
// control word that travels down the pipeline.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int REGW = 5;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic RES_ALU = 1'b0;
    localparam logic RES_MEM = 1'b1;

    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       mem_write;
        logic       result_src;
        logic       branch;
        logic [2:0] alu_control;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: a valid load in execute whose destination is read
// by the valid decode instruction. x0 is never a hazard.
module hazard_detect #(
    parameter int REGW = 5
) (
    input  logic            rst,
    input  logic [REGW-1:0] Rs1D,
    input  logic [REGW-1:0] Rs2D,
    input  logic            ValidD,
    input  logic [REGW-1:0] RdE,
    input  logic            ValidE,
    input  logic            ResultSrcE,
    input  logic            RegWriteE,
    input  logic            FlushE,
    output logic            hz,
    output logic            StallD
);

    logic rd_match;

    always_comb begin
        rd_match = (RdE == Rs1D) || (RdE == Rs2D);
        hz       = ValidD && ValidE && ResultSrcE && RegWriteE
                   && (RdE != '0) && rd_match;
        // A flushed decode slot is wrong-path, so it must not freeze fetch.
        StallD   = hz && !FlushE && !rst;
    end

endmodule

// File: rtl/decode_execute_reg.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and a
// saturating bubble counter for performance debug.
module decode_execute_reg #(
    parameter int XLEN = 32,
    parameter int REGW = 5,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ValidD,
    input  logic            RegWriteD,
    input  logic            ALUSrcD,
    input  logic            MemWriteD,
    input  logic            ResultSrcD,
    input  logic            BranchD,
    input  logic [2:0]      ALUControlD,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic [REGW-1:0] Rs1D,
    input  logic [REGW-1:0] Rs2D,
    input  logic [REGW-1:0] RdD,
    input  logic            FlushE,
    output logic            ValidE,
    output logic            RegWriteE,
    output logic            ALUSrcE,
    output logic            MemWriteE,
    output logic            ResultSrcE,
    output logic            BranchE,
    output logic [2:0]      ALUControlE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [REGW-1:0] Rs1E,
    output logic [REGW-1:0] Rs2E,
    output logic [REGW-1:0] RdE,
    output logic            StallD,
    output logic [CNTW-1:0] BubbleCount
);

    import riscv_pkg::*;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
        return (&c) ? c : c + CNTW'(1);
    endfunction

    ctrl_t           ctrl_p0, ctrl_p1;
    logic            vld_p1;
    logic [XLEN-1:0] rd1_p1, rd2_p1, imm_p1, pc_p1, pc4_p1;
    logic [REGW-1:0] rs1_p1, rs2_p1, rd_p1;
    logic [CNTW-1:0] bubble_cnt;
    logic            hz;

    hazard_detect #(.REGW(REGW)) u_hazard_detect (
        .rst        (rst),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .ValidD     (ValidD),
        .RdE        (rd_p1),
        .ValidE     (vld_p1),
        .ResultSrcE (ctrl_p1.result_src),
        .RegWriteE  (ctrl_p1.reg_write),
        .FlushE     (FlushE),
        .hz         (hz),
        .StallD     (StallD)
    );

    // An invalid decode slot is still captured, but must never commit state.
    always_comb begin
        ctrl_p0             = CTRL_BUBBLE;
        ctrl_p0.reg_write   = RegWriteD && ValidD;
        ctrl_p0.alu_src     = ALUSrcD;
        ctrl_p0.mem_write   = MemWriteD && ValidD;
        ctrl_p0.result_src  = ResultSrcD;
        ctrl_p0.branch      = BranchD;
        ctrl_p0.alu_control = ALUControlD;
    end

    // ---- decode -> execute boundary ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            ctrl_p1    <= CTRL_BUBBLE;
            rd1_p1     <= '0;
            rd2_p1     <= '0;
            imm_p1     <= '0;
            pc_p1      <= '0;
            pc4_p1     <= '0;
            rs1_p1     <= '0;
            rs2_p1     <= '0;
            rd_p1      <= '0;
            bubble_cnt <= '0;
        end else if (FlushE || hz) begin
            // Zeroed indices keep a bubble from matching hazard or forwarding logic.
            vld_p1  <= 1'b0;
            ctrl_p1 <= CTRL_BUBBLE;
            rd1_p1  <= '0;
            rd2_p1  <= '0;
            imm_p1  <= '0;
            pc_p1   <= '0;
            pc4_p1  <= '0;
            rs1_p1  <= '0;
            rs2_p1  <= '0;
            rd_p1   <= '0;
            if (!FlushE) begin
                bubble_cnt <= sat_inc(bubble_cnt);
            end
        end else begin
            vld_p1  <= ValidD;
            ctrl_p1 <= ctrl_p0;
            rd1_p1  <= RD1D;
            rd2_p1  <= RD2D;
            imm_p1  <= ImmExtD;
            pc_p1   <= PCD;
            pc4_p1  <= PCPlus4D;
            rs1_p1  <= Rs1D;
            rs2_p1  <= Rs2D;
            rd_p1   <= RdD;
        end
    end

    assign ValidE      = vld_p1;
    assign RegWriteE   = ctrl_p1.reg_write;
    assign ALUSrcE     = ctrl_p1.alu_src;
    assign MemWriteE   = ctrl_p1.mem_write;
    assign ResultSrcE  = ctrl_p1.result_src;
    assign BranchE     = ctrl_p1.branch;
    assign ALUControlE = ctrl_p1.alu_control;
    assign RD1E        = rd1_p1;
    assign RD2E        = rd2_p1;
    assign ImmExtE     = imm_p1;
    assign PCE         = pc_p1;
    assign PCPlus4E    = pc4_p1;
    assign Rs1E        = rs1_p1;
    assign Rs2E        = rs2_p1;
    assign RdE         = rd_p1;
    assign BubbleCount = bubble_cnt;

endmodule

// File: tb/tb_decode_execute_reg.sv
// Bench for decode_execute_reg: table-driven vectors plus a scoreboard of
// expected E-stage values; a second instance with CNTW=2 covers saturation.
module tb_decode_execute_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        ValidD, RegWriteD, ALUSrcD, MemWriteD, ResultSrcD, BranchD, FlushE;
    logic [2:0]  ALUControlD;
    logic [31:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
    logic [4:0]  Rs1D, Rs2D, RdD;

    logic        ValidE, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, StallD;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic [15:0] BubbleCount;

    logic        s_ValidE, s_RegWriteE, s_ALUSrcE, s_MemWriteE, s_ResultSrcE, s_BranchE, s_StallD;
    logic [2:0]  s_ALUControlE;
    logic [31:0] s_RD1E, s_RD2E, s_ImmExtE, s_PCE, s_PCPlus4E;
    logic [4:0]  s_Rs1E, s_Rs2E, s_RdE;
    logic [1:0]  s_BubbleCount;

    always #5 clk = ~clk;

    decode_execute_reg #(.XLEN(32), .REGW(5), .CNTW(16)) dut (
        .clk(clk), .rst(rst), .ValidD(ValidD), .RegWriteD(RegWriteD), .ALUSrcD(ALUSrcD),
        .MemWriteD(MemWriteD), .ResultSrcD(ResultSrcD), .BranchD(BranchD),
        .ALUControlD(ALUControlD), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
        .PCD(PCD), .PCPlus4D(PCPlus4D), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .FlushE(FlushE), .ValidE(ValidE), .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE),
        .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE), .BranchE(BranchE),
        .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .StallD(StallD), .BubbleCount(BubbleCount)
    );

    decode_execute_reg #(.XLEN(32), .REGW(5), .CNTW(2)) dut_sat (
        .clk(clk), .rst(rst), .ValidD(ValidD), .RegWriteD(RegWriteD), .ALUSrcD(ALUSrcD),
        .MemWriteD(MemWriteD), .ResultSrcD(ResultSrcD), .BranchD(BranchD),
        .ALUControlD(ALUControlD), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
        .PCD(PCD), .PCPlus4D(PCPlus4D), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .FlushE(FlushE), .ValidE(s_ValidE), .RegWriteE(s_RegWriteE), .ALUSrcE(s_ALUSrcE),
        .MemWriteE(s_MemWriteE), .ResultSrcE(s_ResultSrcE), .BranchE(s_BranchE),
        .ALUControlE(s_ALUControlE), .RD1E(s_RD1E), .RD2E(s_RD2E), .ImmExtE(s_ImmExtE),
        .PCE(s_PCE), .PCPlus4E(s_PCPlus4E), .Rs1E(s_Rs1E), .Rs2E(s_Rs2E), .RdE(s_RdE),
        .StallD(s_StallD), .BubbleCount(s_BubbleCount)
    );

    typedef struct {
        logic        vd, rw, as, mw, rs, br, fl;
        logic [2:0]  alu;
        logic [31:0] rd1, rd2, imm, pc, pc4;
        logic [4:0]  rs1, rs2, rd;
        logic        es, ev;   // expected StallD before the edge, ValidE after it
    } vec_t;

    typedef struct {
        logic        vld, rw, as, mw, rs, br;
        logic [2:0]  alu;
        logic [31:0] rd1, rd2, imm, pc, pc4;
        logic [4:0]  rs1, rs2, rd;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    exp_t m;
    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic vd, rw, mw, rs, input logic [2:0] alu,
                                input logic [31:0] rd1, pc, input logic [4:0] rs1, rs2, rd,
                                input logic fl, es, ev);
        vec_t v;
        v.vd = vd; v.rw = rw; v.mw = mw; v.rs = rs; v.alu = alu;
        v.as = alu[1]; v.br = alu[0]; v.fl = fl;
        v.rd1 = rd1; v.rd2 = ~rd1; v.imm = {rd1[15:0], rd1[31:16]};
        v.pc = pc; v.pc4 = pc + 32'd4;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.es = es; v.ev = ev;
        return v;
    endfunction

    function automatic vec_t rnd();
        vec_t v;
        v = mk(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom),
               $urandom, $urandom, 5'($urandom), 5'($urandom), 5'($urandom),
               1'b0, 1'b0, 1'b0);
        return v;
    endfunction

    // One clock: drive D inputs, check StallD, advance the model, check E outputs.
    task automatic apply(input vec_t v, input logic r, input string tag);
        exp_t e, got;
        logic hz;
        rst = r; ValidD = v.vd; RegWriteD = v.rw; ALUSrcD = v.as; MemWriteD = v.mw;
        ResultSrcD = v.rs; BranchD = v.br; ALUControlD = v.alu; RD1D = v.rd1; RD2D = v.rd2;
        ImmExtD = v.imm; PCD = v.pc; PCPlus4D = v.pc4; Rs1D = v.rs1; Rs2D = v.rs2;
        RdD = v.rd; FlushE = v.fl;
        #1;
        check({tag, ".stall"}, 32'(StallD), 32'(v.es));
        hz = v.vd && m.vld && m.rs && m.rw && (m.rd != 5'd0) && (m.rd == v.rs1 || m.rd == v.rs2);
        e = m;
        if (r) begin
            e = '{default: '0};
        end else if (v.fl || hz) begin
            e = '{default: '0};
            e.cnt = m.cnt; e.cnt2 = m.cnt2;
            if (!v.fl) begin
                if (m.cnt != 16'hFFFF) e.cnt = m.cnt + 16'd1;
                if (m.cnt2 != 2'd3) e.cnt2 = m.cnt2 + 2'd1;
            end
        end else begin
            e.vld = v.vd; e.rw = v.rw & v.vd; e.mw = v.mw & v.vd; e.as = v.as;
            e.rs = v.rs; e.br = v.br; e.alu = v.alu; e.rd1 = v.rd1; e.rd2 = v.rd2;
            e.imm = v.imm; e.pc = v.pc; e.pc4 = v.pc4; e.rs1 = v.rs1; e.rs2 = v.rs2; e.rd = v.rd;
        end
        m = e;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check({tag, ".vld"}, 32'(ValidE), 32'(got.vld));
        check({tag, ".ctrl"}, 32'({RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE}),
              32'({got.rw, got.as, got.mw, got.rs, got.br, got.alu}));
        check({tag, ".rd1"}, RD1E, got.rd1);
        check({tag, ".rd2"}, RD2E, got.rd2);
        check({tag, ".imm"}, ImmExtE, got.imm);
        check({tag, ".pc"}, PCE, got.pc);
        check({tag, ".pc4"}, PCPlus4E, got.pc4);
        check({tag, ".idx"}, 32'({Rs1E, Rs2E, RdE}), 32'({got.rs1, got.rs2, got.rd}));
        check({tag, ".cnt"}, 32'(BubbleCount), 32'(got.cnt));
        check({tag, ".cnt2"}, 32'(s_BubbleCount), 32'(got.cnt2));
        if (!r) check({tag, ".vld_tbl"}, 32'(ValidE), 32'(v.ev));
    endtask

    vec_t tbl[16];
    int   sat_exp[5];

    initial begin
        m = '{default: '0};
        // vd rw mw rs alu rd1 pc rs1 rs2 rd fl | es ev
        tbl[0]  = mk(1, 1, 0, 0, 3'b010, 32'hDEADBEEF, 32'h104, 1, 2, 5, 0, 0, 1);  // pass-through
        tbl[1]  = mk(0, 1, 1, 0, 3'b011, 32'h12345678, 32'h108, 3, 4, 6, 0, 0, 0);  // invalid slot
        tbl[2]  = mk(1, 1, 0, 1, 3'b000, 32'h0000AAAA, 32'h10C, 1, 2, 0, 0, 0, 1);  // load x0
        tbl[3]  = mk(1, 1, 0, 0, 3'b001, 32'h0000BBBB, 32'h110, 0, 0, 8, 0, 0, 1);  // reads x0
        tbl[4]  = mk(1, 1, 0, 0, 3'b100, 32'h0000CCCC, 32'h114, 1, 2, 5, 0, 0, 1);  // non-load x5
        tbl[5]  = mk(1, 1, 0, 0, 3'b101, 32'h0000DDDD, 32'h118, 3, 5, 10, 0, 0, 1); // reads x5
        tbl[6]  = mk(1, 1, 0, 1, 3'b000, 32'h11110000, 32'h11C, 1, 2, 5, 0, 0, 1);  // lw x5
        tbl[7]  = mk(1, 1, 0, 0, 3'b000, 32'h22220000, 32'h120, 5, 6, 11, 0, 1, 0); // use -> stall
        tbl[8]  = mk(1, 1, 0, 0, 3'b000, 32'h22220000, 32'h120, 5, 6, 11, 0, 0, 1); // replay
        tbl[9]  = mk(1, 1, 0, 1, 3'b000, 32'h33330000, 32'h124, 1, 2, 7, 0, 0, 1);  // lw x7
        tbl[10] = mk(1, 1, 0, 0, 3'b000, 32'h44440000, 32'h128, 3, 7, 12, 1, 0, 0); // use + flush
        tbl[11] = mk(1, 1, 0, 1, 3'b000, 32'h55550000, 32'h12C, 1, 2, 9, 0, 0, 1);  // lw x9
        tbl[12] = mk(1, 1, 0, 0, 3'b010, 32'h66660000, 32'h130, 9, 9, 13, 0, 1, 0); // both match
        tbl[13] = mk(1, 1, 0, 0, 3'b010, 32'h66660000, 32'h130, 9, 9, 13, 0, 0, 1); // replay
        tbl[14] = mk(1, 1, 0, 1, 3'b000, 32'h77770000, 32'h134, 1, 2, 3, 0, 0, 1);  // lw x3
        tbl[15] = mk(0, 1, 0, 0, 3'b000, 32'h88880000, 32'h138, 3, 4, 14, 0, 0, 0); // invalid use
        sat_exp = '{1, 2, 3, 3, 3};

        apply(rnd(), 1'b1, "rst0");
        apply(rnd(), 1'b1, "rst1");
        check("rst.cnt_zero", 32'(BubbleCount), 32'd0);
        apply(mk(1, 0, 0, 0, 3'b000, 32'h0, 32'h100, 1, 2, 3, 0, 0, 1), 1'b0, "release");
        check("release.pce", PCE, 32'h100);

        for (int i = 0; i < 16; i++) apply(tbl[i], 1'b0, $sformatf("vec%0d", i));
        check("table.cnt_total", 32'(BubbleCount), 32'd2);

        // Reset arriving in the stall cycle drops the hazard entirely.
        apply(tbl[6], 1'b0, "rmid.lw");
        apply(mk(1, 1, 0, 0, 3'b000, 32'h9, 32'h140, 5, 1, 4, 0, 0, 0), 1'b1, "rmid.rst");
        apply(mk(1, 1, 0, 0, 3'b000, 32'h9, 32'h140, 5, 1, 4, 0, 0, 1), 1'b0, "rmid.after");

        // Saturation of the 2-bit counter over five load-use pairs.
        apply(rnd(), 1'b1, "sat.rst");
        for (int k = 0; k < 5; k++) begin
            apply(tbl[6], 1'b0, $sformatf("sat%0d.lw", k));
            apply(tbl[7], 1'b0, $sformatf("sat%0d.use", k));
            check($sformatf("sat%0d.count", k), 32'(s_BubbleCount), 32'(sat_exp[k]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_execute_reg.md
Name: decode_execute_reg

Overview:
- ID/EX pipeline register. Captures the decode-stage control word from the control unit, plus register operands, immediate, PC values and register indices, and presents them to the execute stage one cycle later.
- Contains load-use hazard detection. On a load-use hazard it stalls fetch/decode and inserts a bubble into execute.
- Accepts a branch-taken flush from execute.
- Keeps a saturating bubble counter for performance debug.

Parameters:
- XLEN, 32, datapath width for operands, immediate and PC.
- REGW, 5, register index width.
- CNTW, 16, width of the bubble performance counter.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- ValidD  in  1  decode slot holds a real instruction.
- RegWriteD, ALUSrcD, MemWriteD, ResultSrcD, BranchD  in  1 each  decode control bits; ResultSrcD=1 means load.
- ALUControlD  in  3  ALU operation select.
- RD1D, RD2D  in  XLEN  register file read data.
- ImmExtD  in  XLEN  sign-extended immediate.
- PCD, PCPlus4D  in  XLEN  instruction PC and PC+4.
- Rs1D, Rs2D, RdD  in  REGW  source and destination indices.
- FlushE  in  1  branch taken in execute; kill the instruction entering execute.
- ValidE, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE  out  1 each  registered control.
- ALUControlE  out  3  registered ALU select.
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  XLEN  registered data.
- Rs1E, Rs2E, RdE  out  REGW  registered indices (used by forwarding).
- StallD  out  1  combinational; hold the PC and IF/ID register this cycle.
- BubbleCount  out  CNTW  number of load-use bubbles inserted, saturating.

Behaviour:
- Reset:
  - When rst=1 at a clock edge, every registered output goes to 0, including ValidE and BubbleCount.
  - StallD is forced to 0 while rst=1.
  - A reset mid-stall drops the pending hazard; no state survives.
- Latency: exactly 1 cycle from the D inputs to the E outputs. There is no hold mode; the E stage is never stalled.
- Load-use hazard, combinational:
  - hz = ValidD & ValidE & ResultSrcE & RegWriteE & (RdE != 0) & ((RdE == Rs1D) | (RdE == Rs2D)).
  - Index x0 never raises a hazard.
- StallD = hz & ~FlushE & ~rst.
- Per-edge priority, highest first:
  1. rst: as above.
  2. FlushE=1: load a bubble. Hazard is ignored because the decode instruction is wrong-path. BubbleCount is unchanged.
  3. hz=1: load a bubble. BubbleCount increments by 1, saturating at 2^CNTW-1.
  4. Otherwise: capture all D inputs. ValidE=ValidD.
- Bubble: ValidE=0, all E control bits 0, ALUControlE=0, all data and index outputs 0. Zeroed indices guarantee a bubble can never trigger hz or forwarding.
- ValidD=0 with no flush/hazard: the fields are still captured, but ValidE=0, and RegWriteE and MemWriteE are forced to 0.
- After one bubble, the load has left the E slot, so hz clears next cycle unless a new load is in E. The stall therefore lasts exactly 1 cycle per load-use pair.
- Simultaneous rd match on both Rs1D and Rs2D: a single hazard, one bubble.
- Widths: index comparisons are REGW-bit equality. No arithmetic except the CNTW-bit saturating increment.

Decomposition:
- Shared package riscv_pkg:
  - XLEN and REGW constants.
  - ALUControl encoding localparams (ADD, SUB, AND, OR, SLT, ...).
  - ResultSrc encoding (0=ALU, 1=memory).
  - A packed control-word typedef ctrl_t {RegWrite, ALUSrc, MemWrite, ResultSrc, Branch, ALUControl[2:0]} with the constant CTRL_BUBBLE = '0.
- One natural sub-module: hazard_detect. It is purely combinational, takes Rs1D, Rs2D, ValidD, RdE, ValidE, ResultSrcE, RegWriteE, FlushE, and produces hz and StallD. The register and counter stay in the top.

Test Plan:
- Reset: drive rst=1 for 2 cycles with random D inputs -> all E outputs 0, BubbleCount=0, StallD=0. Release -> the next edge captures D (e.g. PCD=0x100 gives PCE=0x100 one cycle later).
- Pass-through: ValidD=1, RegWriteD=1, ALUControlD=3'b010, RD1D=0xDEADBEEF, RdD=5, no hazard -> next cycle ValidE=1, ALUControlE=3'b010, RD1E=0xDEADBEEF, RdE=5, StallD=0.
- Load-use: cycle 0 lw x5 (ResultSrcD=1, RegWriteD=1, RdD=5).
  - Cycle 1: add with Rs1D=5 -> StallD=1.
  - Cycle 2: bubble in E (ValidE=0, RdE=0), BubbleCount=1, StallD=0.
  - Cycle 3: add captured.
- x0 / non-load: a load with RdE=0 and Rs1D=0 -> StallD=0. A non-load with RdE=5 and Rs2D=5 -> StallD=0.
- Flush vs hazard: hazard condition true and FlushE=1 in the same cycle -> StallD=0, bubble in E, BubbleCount unchanged.
- Saturation: CNTW=2, force 5 consecutive load-use pairs -> BubbleCount reads 1, 2, 3, 3, 3.
